// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, saturation limits and state type for the conv accumulator
package conv_pkg;

    localparam int ACC_W = 32;

    localparam logic [ACC_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [ACC_W-1:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/thirty_two_bit_adder.sv
// rtl/thirty_two_bit_adder.sv - 32-bit ripple-carry adder built from full-adder cells
module thirty_two_bit_adder
    import conv_pkg::*;
(
    input  logic [ACC_W-1:0] A,
    input  logic [ACC_W-1:0] B,
    input  logic             Cin,
    output logic [ACC_W-1:0] Sum,
    output logic             Cout
);

    logic [ACC_W:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < ACC_W; i++) begin : g_fa
        assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry[ACC_W];

endmodule

// File: rtl/conv_accumulator.sv
// rtl/conv_accumulator.sv - sums TAPS signed products per window; CONV_ACC_SAT_EN selects saturating accumulate
module conv_accumulator
    import conv_pkg::*;
#(
    parameter int TAPS   = 9,
    parameter int PROD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int              CNT_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    acc_state_t        state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic              ovf_q;
    logic              ovf_d;
    logic [CNT_W-1:0]  tap_cnt_q;
    logic [ACC_W-1:0]  out_sum_q;
    logic              out_ovf_q;
    logic              out_valid_q;
    logic              in_ready_q;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  add_sum;
    logic              add_cout_unused;
    logic              add_ovf;

    assign prod_ext = ACC_W'($signed(in_prod));

    thirty_two_bit_adder u_adder (
        .A    (acc_q),
        .B    (prod_ext),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout_unused)
    );

    // Signed overflow: both operands share a sign and the result sign flips.
    assign add_ovf = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (add_sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        acc_d = add_sum;
`ifdef CONV_ACC_SAT_EN
        if (add_ovf) begin
            acc_d = acc_q[ACC_W-1] ? SAT_NEG : SAT_POS;
        end
`endif
        ovf_d = ovf_q | add_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            tap_cnt_q   <= '0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        acc_q     <= acc_d;
                        ovf_q     <= ovf_d;
                        tap_cnt_q <= tap_cnt_q + 1'b1;
                        if (tap_cnt_q == LAST_TAP) begin
                            out_sum_q   <= acc_d;
                            out_ovf_q   <= ovf_d;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        tap_cnt_q   <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// tb/tb_conv_accumulator.sv - self-checking bench for conv_accumulator (CONV_ACC_SAT_EN aware)
module tb_conv_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, out_ready;
    logic [15:0] in_prod;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_sum;

    logic        v2, r2;
    logic [31:0] p2;
    logic        rdy2, vld2, ovf2;
    logic [31:0] sum2;

    logic        v1, r1;
    logic [15:0] p1;
    logic        rdy1, vld1, ovf1;
    logic [31:0] sum1;

    conv_accumulator #(.TAPS(9), .PROD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf)
    );

    conv_accumulator #(.TAPS(2), .PROD_W(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_prod(p2),
        .out_valid(vld2), .out_ready(r2), .out_sum(sum2), .out_ovf(ovf2)
    );

    conv_accumulator #(.TAPS(1), .PROD_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_prod(p1),
        .out_valid(vld1), .out_ready(r1), .out_sum(sum1), .out_ovf(ovf1)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model for the TAPS=9 instance: products of the open window, and
    // the total/flag the window must produce once it is complete.
    int          mq[$];
    bit          m_hold = 1'b0;
    logic [31:0] m_sum  = '0;
    bit          m_ovf  = 1'b0;

    function automatic void window_total(output logic [31:0] s, output bit o);
        longint a = 0;
        longint r;
        o = 1'b0;
        foreach (mq[i]) begin
            r = a + longint'(mq[i]);
            if (r > 64'sd2147483647 || r < -64'sd2147483648) begin
                o = 1'b1;
`ifdef CONV_ACC_SAT_EN
                a = (r > 0) ? 64'sd2147483647 : -64'sd2147483648;
`else
                a = longint'(int'(r));
`endif
            end else begin
                a = r;
            end
        end
        s = a[31:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) begin
                mq.push_back(int'($signed(in_prod)));
                if (mq.size() == 9) begin
                    window_total(m_sum, m_ovf);
                    m_hold = 1'b1;
                end
            end
        end else if (out_ready) begin
            m_hold = 1'b0;
            mq.delete();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, !m_hold});
            chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_hold});
            if (m_hold) begin
                chk("cmp_out_sum", out_sum, m_sum);
                chk("cmp_out_ovf", {31'b0, out_ovf}, {31'b0, m_ovf});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] p);
        bit ok;
        in_valid = 1'b1;
        in_prod  = p;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) return;
        end
        checks++;
        errors++;
        $display("FAIL push_timeout: in_ready stayed 0 for 50 cycles, expected 1");
    endtask

    int mix[9] = '{100, -250, 7, 0, -1, 30000, -30000, 5, 4};

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_prod = '0;
        v2 = 1'b0; r2 = 1'b1; p2 = '0;
        v1 = 1'b0; r1 = 1'b1; p1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
        #1 rst_n = 1'b1;
        step();

        // Nine products of 1
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) push(16'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", {31'b0, out_valid}, 32'd1);
        chk("t1_sum", out_sum, 32'd9);
        chk("t1_model_sum", m_sum, 32'd9);
        chk("t1_ovf", {31'b0, out_ovf}, 32'd0);
        chk("t1_in_ready_low", {31'b0, in_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("t1_in_ready_back", {31'b0, in_ready}, 32'd1);
        chk("t1_valid_drop", {31'b0, out_valid}, 32'd0);
        step();

        // Mixed signs
        for (int i = 0; i < 9; i++) push(16'(mix[i]));
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_sum", out_sum, 32'hFFFF_FF79);
        chk("t2_model_sum", m_sum, 32'hFFFF_FF79);
        chk("t2_ovf", {31'b0, out_ovf}, 32'd0);
        step();
        step();

        // Back-pressure in HOLD with in_valid kept high
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(16'($urandom_range(0, 65535)));
        in_prod = 16'h1234;
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("t3_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t3_hold_sum", out_sum, m_sum);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 9; k++) push(16'(k));
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_next_sum", out_sum, 32'd45);
        step();
        step();

        // Asynchronous reset after tap 4
        for (int i = 0; i < 4; i++) push(16'd5);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t4_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("t4_rst_sum", out_sum, 32'd0);
        chk("t4_rst_ovf", {31'b0, out_ovf}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 9; i++) push(16'd2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_sum", out_sum, 32'd18);
        step();
        step();

        // Randomized traffic with random back-pressure and extreme products
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 5))
                0:       in_prod = 16'h7FFF;
                1:       in_prod = 16'h8000;
                default: in_prod = 16'($urandom);
            endcase
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // TAPS=2, 32-bit products: overflow both directions, then a clean window
        v2 = 1'b1; p2 = 32'h7FFF_FFFF;
        step();
        p2 = 32'd1;
        step();
        v2 = 1'b0;
        @(negedge clk);
        chk("d2_valid", {31'b0, vld2}, 32'd1);
        chk("d2_in_ready", {31'b0, rdy2}, 32'd0);
`ifdef CONV_ACC_SAT_EN
        chk("d2_pos_sum", sum2, 32'h7FFF_FFFF);
`else
        chk("d2_pos_sum", sum2, 32'h8000_0000);
`endif
        chk("d2_pos_ovf", {31'b0, ovf2}, 32'd1);
        step();
        v2 = 1'b1; p2 = 32'h8000_0000;
        step();
        p2 = 32'hFFFF_FFFF;
        step();
        v2 = 1'b0;
        @(negedge clk);
`ifdef CONV_ACC_SAT_EN
        chk("d2_neg_sum", sum2, 32'h8000_0000);
`else
        chk("d2_neg_sum", sum2, 32'h7FFF_FFFF);
`endif
        chk("d2_neg_ovf", {31'b0, ovf2}, 32'd1);
        step();
        v2 = 1'b1; p2 = 32'd5;
        step();
        p2 = 32'hFFFF_FFFE;
        step();
        v2 = 1'b0;
        @(negedge clk);
        chk("d2_clean_sum", sum2, 32'd3);
        chk("d2_clean_ovf", {31'b0, ovf2}, 32'd0);
        step();

        // TAPS=1, back-to-back products 3 and -3
        v1 = 1'b1; p1 = 16'd3;
        step();
        p1 = 16'hFFFD;
        @(negedge clk);
        chk("d1_first_valid", {31'b0, vld1}, 32'd1);
        chk("d1_first_sum", sum1, 32'd3);
        step();
        @(negedge clk);
        chk("d1_gap_valid", {31'b0, vld1}, 32'd0);
        chk("d1_gap_ready", {31'b0, rdy1}, 32'd1);
        step();
        v1 = 1'b0;
        @(negedge clk);
        chk("d1_second_valid", {31'b0, vld1}, 32'd1);
        chk("d1_second_sum", sum1, 32'hFFFF_FFFD);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

- Sequential accumulation stage directly downstream of the convolution multiplier array.
- Accepts one signed product per valid/ready handshake and sums TAPS products into a 32-bit window total, using one `thirty_two_bit_adder` instance as its datapath adder.
- Presents the total on a valid/ready output with a signed-overflow flag, then clears for the next window.

## Interface
- `TAPS`, default 9: products per window (3x3 kernel); legal range 1..65535.
- `PROD_W`, default 16: width of the incoming signed product; legal range 2..32.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_prod` valid.
- `in_ready`  out  1  block can accept a product this cycle.
- `in_prod`  in  PROD_W  signed two's-complement product.
- `out_valid`  out  1  `out_sum`/`out_ovf` hold a completed window.
- `out_ready`  in  1  consumer accepts the window this cycle.
- `out_sum`  out  32  signed window total.
- `out_ovf`  out  1  sticky: at least one add in the window overflowed signed 32-bit.

## Operation
- The FSM has two states.
- **ACCUM (reset state)**
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid && in_ready`: `acc` <= `acc` + sign-extend-to-32(`in_prod`). The adder has `Cin` tied to 0.
  - Also on that handshake: `ovf_sticky` |= (operand signs equal && result sign differs); `tap_cnt` += 1.
  - When the accepted product is tap `TAPS-1`, load `out_sum` and `out_ovf` with the post-add values, then go to HOLD.
  - No handshake: all state holds.
- **HOLD**
  - `in_ready` = 0, `out_valid` = 1. `in_valid` is ignored; no product is consumed.
  - On `out_ready`: clear `acc`, `ovf_sticky` and `tap_cnt`, then go to ACCUM.
- `tap_cnt` is $clog2(TAPS) bits wide, minimum 1 bit. It never wraps, because it clears on leaving HOLD.
- `TAPS` = 1: every accepted product goes straight to HOLD; `out_sum` = the sign-extended product.
- `out_sum` and `out_ovf` are stable throughout HOLD. They keep their last value in ACCUM, but are meaningful only while `out_valid` is high.
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_sum` = 0, `out_ovf` = 0, `acc` = 0, `tap_cnt` = 0, state = ACCUM.
- Reset asserted mid-window discards the partial sum immediately (asynchronous). The first handshake after reset release starts tap 0.

## Timing
- Product accept rate is 1 per cycle within a window.
- The window total is visible on `out_valid` in the cycle after the last-tap handshake (1-cycle latency).
- Minimum period per window is TAPS+1 cycles, because HOLD lasts at least one cycle. With `out_ready` held high, `in_ready` returns the cycle after HOLD.
- Output handshake completes on any edge where `out_valid && out_ready`. `out_ready` may be high before `out_valid` rises.
- `in_ready` does not depend combinationally on `out_ready`; it is a function of state only.
- The adder is a combinational ripple chain of 32 full-adder delays, contained in one cycle between `acc` and its register.

## Configuration
- `CONV_ACC_SAT_EN` defined:
  - An overflowing add clamps `acc` to 32'h7FFF_FFFF for positive overflow, or 32'h8000_0000 for negative overflow.
  - Later adds proceed from the clamped value.
  - `out_ovf` behaviour is unchanged.
- `CONV_ACC_SAT_EN` undefined: `acc` wraps modulo 2^32; `out_ovf` is still reported.

## Structure
- Shared package `conv_pkg`:
  - `ACC_W` = 32.
  - `SAT_POS`/`SAT_NEG` constants.
  - `acc_state_t` enum {ACCUM, HOLD}.
- Sub-module: one `thirty_two_bit_adder`, with A = `acc`, B = the sign-extended product, `Cin` = 0. `Cout` is unused; overflow comes from the sign bits.
- No other sub-module.

## Test plan
- Reset, then TAPS=9 products of 16'sd1 with `out_ready` = 1 → `out_valid` rises the cycle after the 9th handshake, `out_sum` = 9, `out_ovf` = 0, `in_ready` back one cycle later.
- Mixed signs, products {100, -250, 7, 0, -1, 30000, -30000, 5, 4} → `out_sum` = -135 (32'hFFFF_FF79).
- `out_ready` held low for 5 cycles in HOLD while `in_valid` = 1 → `out_sum` stable, no product consumed; the next window starts correctly after `out_ready`.
- Overflow with PROD_W = 32, TAPS = 2, products 32'h7FFF_FFFF then 1 → `out_ovf` = 1, and:
  - `out_sum` = 32'h8000_0000 without `CONV_ACC_SAT_EN`;
  - `out_sum` = 32'h7FFF_FFFF with `CONV_ACC_SAT_EN`.
- `rst_n` asserted after tap 4 of 9 → outputs return to reset values at once; 9 new products of 2 → `out_sum` = 18.
- TAPS = 1, back-to-back products 3, -3 with `out_ready` = 1 → two windows, `out_sum` 3 then -3, each 2 cycles apart.
